// File: rtl/mixed_edge_pipe.sv
// rtl/mixed_edge_pipe.sv - WIDTH-bit register pipe alternating posedge/negedge stages with valid tracking
// Optional carried-parity check is enabled by defining PIPE_PARITY_EN.
module mixed_edge_pipe #(
  parameter int                 WIDTH    = 8,
  parameter int                 DEPTH    = 4,
  parameter logic [DEPTH-1:0]   INV_MASK = {DEPTH{1'b0}},
  parameter int                 CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rb,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a,
`ifdef PIPE_PARITY_EN
  input  logic             par_inj,
  output logic             par_err,
`endif
  output logic             vld_o,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic ODD = (WIDTH % 2 == 1);

  logic                        en_r;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            v;

  always_ff @(posedge clk or negedge rb) begin
    if (!rb) en_r <= 1'b0;
    else     en_r <= en;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             vin;
    logic [WIDTH-1:0] q;
    logic             qv;

    if (k == 0) begin : g_src
      assign din = a ^ {WIDTH{INV_MASK[k]}};
      assign vin = vld_i;
    end else begin : g_src
      assign din = d[k-1] ^ {WIDTH{INV_MASK[k]}};
      assign vin = v[k-1];
    end

    // Negedge stages use the posedge-registered enable so a token moves as a unit.
    if (k % 2 == 0) begin : g_edge
      always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
          q  <= '0;
          qv <= 1'b0;
        end else if (en) begin
          q  <= din;
          qv <= vin;
        end
      end
    end else begin : g_edge
      always_ff @(negedge clk or negedge rb) begin
        if (!rb) begin
          q  <= '0;
          qv <= 1'b0;
        end else if (en_r) begin
          q  <= din;
          qv <= vin;
        end
      end
    end

    assign d[k] = q;
    assign v[k] = qv;
  end

  assign y     = d[DEPTH-1];
  assign vld_o = v[DEPTH-1];

  always_ff @(negedge clk or negedge rb) begin
    if (!rb)                      cnt_o <= '0;
    else if (en_r && v[DEPTH-2])  cnt_o <= cnt_o + 1'b1;
  end

`ifdef PIPE_PARITY_EN
  logic [DEPTH-2:0] p;
  logic             p_last;
  logic [WIDTH-1:0] d_last;

  // The last stage keeps no parity bit; it is checked against the data as it is captured.
  for (genvar k = 0; k < DEPTH - 1; k++) begin : g_par
    logic pin;
    logic pq;

    if (k == 0) begin : g_src
      assign pin = (^(a ^ {WIDTH{INV_MASK[0]}})) ^ par_inj;
    end else begin : g_src
      assign pin = p[k-1] ^ (INV_MASK[k] & ODD);
    end

    if (k % 2 == 0) begin : g_edge
      always_ff @(posedge clk or negedge rb) begin
        if (!rb)     pq <= 1'b0;
        else if (en) pq <= pin;
      end
    end else begin : g_edge
      always_ff @(negedge clk or negedge rb) begin
        if (!rb)       pq <= 1'b0;
        else if (en_r) pq <= pin;
      end
    end

    assign p[k] = pq;
  end

  assign p_last = p[DEPTH-2] ^ (INV_MASK[DEPTH-1] & ODD);
  assign d_last = d[DEPTH-2] ^ {WIDTH{INV_MASK[DEPTH-1]}};

  always_ff @(negedge clk or negedge rb) begin
    if (!rb)
      par_err <= 1'b0;
    else if (en_r && v[DEPTH-2] && (p_last != ^d_last))
      par_err <= 1'b1;
  end
`endif

endmodule
